// File: rtl/lsu_bus_master.sv
// Load/store bus initiator: computes the effective address, issues one
// valid/ready request per op, waits for the responder's ack, and writes
// aligned/extended load data back to the register file.
module lsu_bus_master #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic        jump_branch_enable,
  input  logic [31:0] src1_value,
  input  logic [31:0] src2_value,
  input  logic [31:0] imm,
  input  logic [4:0]  rd,
  input  logic [5:0]  operation_con,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_rdata,
  output logic        write_req,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [5:0] OP_LB  = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LW  = 6'd3;
  localparam logic [5:0] OP_LBU = 6'd4;
  localparam logic [5:0] OP_LHU = 6'd5;
  localparam logic [5:0] OP_SB  = 6'd6;
  localparam logic [5:0] OP_SH  = 6'd7;
  localparam logic [5:0] OP_SW  = 6'd8;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RSP, WB} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;

  logic        req_valid_d, we_d, wr_req_d, mis_d, err_d;
  logic [31:0] addr_d, wdata_d, wr_data_d;
  logic [3:0]  be_d;
  logic [4:0]  wr_addr_d;

  logic [31:0] ea;
  logic        is_byte, is_half, is_word, is_store, misaligned;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  rsp_byte;
  logic [15:0] rsp_half;
  logic [31:0] load_val;

  assign op_ready = (state_q == IDLE);

  // Decode the presented op and build its address, lane enables and store data
  always_comb begin
    ea        = src1_value + imm;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_word   = 1'b0;
    is_store  = 1'b0;
    case (operation_con)
      OP_LB, OP_LBU: is_byte = 1'b1;
      OP_LH, OP_LHU: is_half = 1'b1;
      OP_LW:         is_word = 1'b1;
      OP_SB: begin is_byte = 1'b1; is_store = 1'b1; end
      OP_SH: begin is_half = 1'b1; is_store = 1'b1; end
      OP_SW: begin is_word = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
    misaligned = (is_half & ea[0]) | (is_word & (ea[1:0] != 2'b00));
    be_new     = 4'b1111;
    wdata_new  = src2_value;
    if (is_byte) begin
      be_new    = 4'b0001 << ea[1:0];
      wdata_new = {4{src2_value[7:0]}};
    end else if (is_half) begin
      be_new    = 4'b0011 << {ea[1], 1'b0};
      wdata_new = {2{src2_value[15:0]}};
    end
  end

  // Select and extend the addressed lane(s) of the returned word
  always_comb begin
    case (off_q)
      2'd0:    rsp_byte = bus_rsp_rdata[7:0];
      2'd1:    rsp_byte = bus_rsp_rdata[15:8];
      2'd2:    rsp_byte = bus_rsp_rdata[23:16];
      default: rsp_byte = bus_rsp_rdata[31:24];
    endcase
    rsp_half = off_q[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
    case (op_q)
      OP_LB:   load_val = {{24{rsp_byte[7]}}, rsp_byte};
      OP_LBU:  load_val = {24'd0, rsp_byte};
      OP_LH:   load_val = {{16{rsp_half[15]}}, rsp_half};
      OP_LHU:  load_val = {16'd0, rsp_half};
      default: load_val = bus_rsp_rdata;
    endcase
  end

  // Next-state and next-output logic for the transaction sequencer
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    op_d        = op_q;
    rd_d        = rd_q;
    req_valid_d = bus_req_valid;
    addr_d      = bus_addr;
    we_d        = bus_we;
    be_d        = bus_be;
    wdata_d     = bus_wdata;
    wr_req_d    = 1'b0;
    wr_addr_d   = write_addr;
    wr_data_d   = write_data;
    mis_d       = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (op_valid && !jump_branch_enable && (is_byte || is_half || is_word)) begin
          if (misaligned) begin
            mis_d = 1'b1;
          end else begin
            req_valid_d = 1'b1;
            addr_d      = {ea[31:2], 2'b00};
            off_d       = ea[1:0];
            op_d        = operation_con;
            rd_d        = rd;
            we_d        = is_store;
            be_d        = be_new;
            wdata_d     = wdata_new;
            state_d     = REQ;
          end
        end
      end
      REQ: begin
        if (bus_req_ready) begin
          req_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (bus_rsp_valid) begin
          if (bus_we) begin
            state_d = IDLE;
          end else begin
            wr_req_d  = (rd_q != 5'd0);
            wr_addr_d = rd_q;
            wr_data_d = load_val;
            state_d   = WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      off_q         <= '0;
      op_q          <= '0;
      rd_q          <= '0;
      bus_req_valid <= 1'b0;
      bus_addr      <= '0;
      bus_we        <= 1'b0;
      bus_be        <= '0;
      bus_wdata     <= '0;
      write_req     <= 1'b0;
      write_addr    <= '0;
      write_data    <= '0;
      misalign_err  <= 1'b0;
      bus_err       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      off_q         <= off_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      bus_req_valid <= req_valid_d;
      bus_addr      <= addr_d;
      bus_we        <= we_d;
      bus_be        <= be_d;
      bus_wdata     <= wdata_d;
      write_req     <= wr_req_d;
      write_addr    <= wr_addr_d;
      write_data    <= wr_data_d;
      misalign_err  <= mis_d;
      bus_err       <= err_d;
    end
  end

endmodule
